mux_source_arbiter: RTL

- Round-robin arbiter that shares one 64-bit three-input datapath mux between three requesters (A, B, C) using valid/ready/last streams.
- Drives the mux's 2-bit selector: 00=A, 01=B, 10=C, 11=idle (mux outputs 0).
- Holds a grant for a whole burst and forwards the handshake between the winning source and the single downstream consumer.
- Sits between the CPU-side producers and the shared 64-bit result/writeback path.

---
 rtl/mux_source_arbiter_if.sv | 41 ++++
 rtl/mux_source_arbiter.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/mux_source_arbiter_if.sv
// Handshake bundle between the three requesters, the arbiter and the
// single downstream consumer of the shared 64-bit result path.
// The master modport is the arbiter's view; slave is the surrounding logic.
interface mux_source_arbiter_if #(
  parameter int DATA_W = 64
);
  logic              a_valid;
  logic              b_valid;
  logic              c_valid;
  logic [DATA_W-1:0] a_data;
  logic [DATA_W-1:0] b_data;
  logic [DATA_W-1:0] c_data;
  logic              a_last;
  logic              b_last;
  logic              c_last;
  logic              a_ready;
  logic              b_ready;
  logic              c_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              out_ready;

  modport master (
    input  a_valid, b_valid, c_valid,
    input  a_data, b_data, c_data,
    input  a_last, b_last, c_last,
    output a_ready, b_ready, c_ready,
    output out_valid, out_data, out_last,
    input  out_ready
  );

  modport slave (
    output a_valid, b_valid, c_valid,
    output a_data, b_data, c_data,
    output a_last, b_last, c_last,
    input  a_ready, b_ready, c_ready,
    input  out_valid, out_data, out_last,
    output out_ready
  );
endinterface

// File: rtl/mux_source_arbiter.sv
// Round-robin arbiter for the shared three-input 64-bit datapath mux.
// A grant is held for a whole burst (or until MAX_BURST beats), then one
// idle bubble cycle precedes the next arbitration.
//
// state | meaning
// IDLE  | selector=11, no source connected, arbitrating among valids
// GRANT | selector holds the winner, handshake passed straight through
module mux_source_arbiter #(
  parameter int DATA_W    = 64,
  parameter int MAX_BURST = 16,
  parameter int CNT_W     = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  mux_source_arbiter_if.master bus,
  output logic [1:0]          selector,
  output logic                busy,
  output logic                burst_err
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  localparam logic [1:0] SEL_A    = 2'b00;
  localparam logic [1:0] SEL_B    = 2'b01;
  localparam logic [1:0] SEL_C    = 2'b10;
  localparam logic [1:0] SEL_IDLE = 2'b11;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_BURST - 1);

  state_t            state;
  logic [CNT_W-1:0]  beat_cnt;
  logic [1:0]        rr_ptr;

  logic              g_valid;
  logic              g_last;
  logic              at_limit;
  logic              xfer;
  logic              burst_end;
  logic [2:0]        req;
  logic [1:0]        p0, p1, p2;
  logic              win_found;
  logic [1:0]        winner;

  // Next requester index in round-robin order; C wraps back to A.
  function automatic logic [1:0] nxt(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Selector-driven mux: only the granted source sees out_ready; idle outputs zero.
  always_comb begin
    g_valid       = 1'b0;
    g_last        = 1'b0;
    bus.out_data  = '0;
    bus.a_ready   = 1'b0;
    bus.b_ready   = 1'b0;
    bus.c_ready   = 1'b0;
    case (selector)
      SEL_A: begin
        g_valid      = bus.a_valid;
        g_last       = bus.a_last;
        bus.out_data = bus.a_data;
        bus.a_ready  = bus.out_ready;
      end
      SEL_B: begin
        g_valid      = bus.b_valid;
        g_last       = bus.b_last;
        bus.out_data = bus.b_data;
        bus.b_ready  = bus.out_ready;
      end
      SEL_C: begin
        g_valid      = bus.c_valid;
        g_last       = bus.c_last;
        bus.out_data = bus.c_data;
        bus.c_ready  = bus.out_ready;
      end
      default: ;
    endcase
  end

  assign at_limit      = (beat_cnt == LAST_IDX);
  assign bus.out_valid = g_valid;
  assign bus.out_last  = (selector != SEL_IDLE) && (g_last || at_limit);
  assign xfer          = g_valid && bus.out_ready;
  assign burst_end     = xfer && (g_last || at_limit);

  // First valid requester starting from rr_ptr wins.
  always_comb begin
    req       = {bus.c_valid, bus.b_valid, bus.a_valid};
    p0        = rr_ptr;
    p1        = nxt(p0);
    p2        = nxt(p1);
    win_found = |req;
    if (req[p0])      winner = p0;
    else if (req[p1]) winner = p1;
    else              winner = p2;
  end

  // Grant FSM with registered selector, busy, beat counter and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      selector  <= SEL_IDLE;
      busy      <= 1'b0;
      beat_cnt  <= '0;
      rr_ptr    <= SEL_A;
      burst_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            state    <= GRANT;
            selector <= winner;
            busy     <= 1'b1;
          end
        end
        GRANT: begin
          if (burst_end) begin
            state    <= IDLE;
            selector <= SEL_IDLE;
            busy     <= 1'b0;
            beat_cnt <= '0;
            rr_ptr   <= nxt(selector);
            // A burst that also ends with a real last on the final allowed beat is legal.
            if (!g_last) burst_err <= 1'b1;
          end else if (xfer) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          selector <= SEL_IDLE;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
